// File: rtl/dpram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_burst_ctrl
// Purpose  : Burst read/write sequencer for a simple dual-port RAM with a
//            registered write port and a fixed-latency read port.
//            A request latched in IDLE produces Len+1 consecutive beats at
//            incrementing addresses that wrap modulo 2^ADDR_W.
// Ports    : clk, ar (async active-high reset)
//            RD, WR, A, Len, DIn        - request side (RD/WR seen in IDLE only)
//            DInReq                     - write-beat strobe, DIn taken this edge
//            DOut, DOutValid            - registered read data
//            Done, Busy                 - completion pulse / not-IDLE status
//            Data, Wr_A, WE             - RAM write port (registered)
//            Rd_A, Q                    - RAM read port
// Revision : 1.0 - initial release
// ============================================================================
module dpram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] A,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] DIn,
    output logic              DInReq,
    output logic [DATA_W-1:0] DOut,
    output logic              DOutValid,
    output logic              Done,
    output logic              Busy,
    output logic [DATA_W-1:0] Data,
    output logic [ADDR_W-1:0] Wr_A,
    output logic              WE,
    output logic [ADDR_W-1:0] Rd_A,
    input  logic [DATA_W-1:0] Q
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_write = 3'd1;
    localparam logic [2:0] c_st_read  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Valid-pipe pattern meaning "only the final read beat is still in flight".
    localparam logic [RD_LAT-1:0] c_vpipe_top = RD_LAT'(1) << (RD_LAT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [RD_LAT-1:0] r_vpipe;
    logic              r_we;
    logic [ADDR_W-1:0] r_wr_a;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              w_last_beat;
    logic              w_vpipe_last;

    // Equality compare against the latched length means Len = all-ones
    // simply runs the counter to its maximum; no extra count bit is needed.
    assign w_last_beat  = (r_cnt == r_len);
    assign w_vpipe_last = (r_vpipe == c_vpipe_top);

    always_comb begin
        w_next = r_state;
        DInReq = 1'b0;
        Busy   = 1'b1;
        Done   = 1'b0;
        case (r_state)
            c_st_idle: begin
                Busy = 1'b0;
                if (WR)      w_next = c_st_write;   // write wins a tie
                else if (RD) w_next = c_st_read;
            end
            c_st_write: begin
                DInReq = 1'b1;
                if (w_last_beat) w_next = c_st_done;
            end
            c_st_read: begin
                if (w_last_beat) w_next = c_st_drain;
            end
            c_st_drain: begin
                // Beats are issued back to back, so once only the top bit is
                // left the next edge captures the final beat into DOut.
                if (w_vpipe_last) w_next = c_st_done;
            end
            c_st_done: begin
                Done   = 1'b1;
                w_next = c_st_idle;
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_vpipe      <= '0;
            r_we         <= 1'b0;
            r_wr_a       <= '0;
            r_data       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_we         <= 1'b0;
            r_vpipe      <= (r_vpipe << 1) | RD_LAT'(r_state == c_st_read);
            r_dout_valid <= r_vpipe[RD_LAT-1];
            if (r_vpipe[RD_LAT-1]) r_dout <= Q;

            case (r_state)
                c_st_idle: begin
                    if (WR || RD) begin
                        r_addr <= A;
                        r_len  <= Len;
                        r_cnt  <= '0;
                    end
                end
                c_st_write: begin
                    r_we   <= 1'b1;
                    r_wr_a <= r_addr;
                    r_data <= DIn;
                    r_addr <= r_addr + 1'b1;   // natural wrap at 2^ADDR_W
                    r_cnt  <= r_cnt + 1'b1;
                end
                c_st_read: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign WE        = r_we;
    assign Wr_A      = r_wr_a;
    assign Data      = r_data;
    assign Rd_A      = r_addr;
    assign DOut      = r_dout;
    assign DOutValid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_dpram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_burst_ctrl
// Purpose  : Self-checking bench for dpram_burst_ctrl with an attached RAM
//            and a transaction-level reference memory. Expected per-cycle
//            behaviour is derived from request cycle, Len and RD_LAT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_burst_ctrl #(
    parameter int RD_LAT = 1
);

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              ar  = 1'b0;
    logic              RD  = 1'b0;
    logic              WR  = 1'b0;
    logic [ADDR_W-1:0] A   = '0;
    logic [LEN_W-1:0]  Len = '0;
    logic [DATA_W-1:0] DIn = '0;
    logic              DInReq;
    logic [DATA_W-1:0] DOut;
    logic              DOutValid;
    logic              Done;
    logic              Busy;
    logic [DATA_W-1:0] Data;
    logic [ADDR_W-1:0] Wr_A;
    logic              WE;
    logic [ADDR_W-1:0] Rd_A;
    logic [DATA_W-1:0] Q;

    dpram_burst_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) u_dut (
        .clk(clk), .ar(ar), .RD(RD), .WR(WR), .A(A), .Len(Len), .DIn(DIn),
        .DInReq(DInReq), .DOut(DOut), .DOutValid(DOutValid), .Done(Done),
        .Busy(Busy), .Data(Data), .Wr_A(Wr_A), .WE(WE), .Rd_A(Rd_A), .Q(Q)
    );

    always #5 clk = ~clk;

    // Attached RAM: registered write, RD_LAT-cycle read latency.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] qp  [RD_LAT];
    assign Q = qp[RD_LAT-1];

    always @(posedge clk) begin
        if (WE) ram[Wr_A] <= Data;
        qp[0] <= ram[Rd_A];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end

    // Reference memory, updated per completed write transaction.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wd [16];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request accepted at edge k; loop index j denotes cycle k+j.
    task automatic do_write(input logic [ADDR_W-1:0] a, input int len, input bit both, input bit noise);
        int ai   = int'(a);
        int last = len + 3;
        WR  = 1'b1;
        RD  = both;
        A   = a;
        Len = LEN_W'(len);
        step();
        WR = 1'b0;
        RD = 1'b0;
        for (int j = 1; j <= last; j++) begin
            check_val("w_dinreq", DInReq, (j <= len + 1));
            check_val("w_we", WE, (j >= 2 && j <= len + 2));
            if (j >= 2 && j <= len + 2) begin
                check_val("w_addr", Wr_A, (ai + j - 2) % DEPTH);
                check_val("w_data", Data, wd[j-2]);
            end
            check_val("w_done", Done, (j == len + 2));
            check_val("w_busy", Busy, (j <= len + 2));
            check_val("w_dvalid", DOutValid, 0);
            DIn = (j <= len + 1) ? wd[j-1] : DATA_W'($urandom);
            if (noise && j < last) begin
                RD = 1'($urandom);
                WR = 1'($urandom);
            end else begin
                RD = 1'b0;
                WR = 1'b0;
            end
            if (j < last) step();
        end
        for (int i = 0; i <= len; i++) ref_mem[(ai + i) % DEPTH] = wd[i];
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int len, input bit noise);
        int  ai   = int'(a);
        int  last = len + 3 + RD_LAT;
        bit  v;
        RD  = 1'b1;
        WR  = 1'b0;
        A   = a;
        Len = LEN_W'(len);
        step();
        RD = 1'b0;
        for (int j = 1; j <= last; j++) begin
            v = (j >= 2 + RD_LAT && j <= len + 2 + RD_LAT);
            check_val("r_busy", Busy, (j <= len + 2 + RD_LAT));
            check_val("r_done", Done, (j == len + 2 + RD_LAT));
            check_val("r_we", WE, 0);
            check_val("r_dinreq", DInReq, 0);
            if (j <= len + 1) check_val("r_rda", Rd_A, (ai + j - 1) % DEPTH);
            check_val("r_dvalid", DOutValid, v);
            if (v) check_val("r_dout", DOut, ref_mem[(ai + j - 2 - RD_LAT) % DEPTH]);
            else if (j == last) check_val("r_hold", DOut, ref_mem[(ai + len) % DEPTH]);
            if (noise && j < last) begin
                RD = 1'($urandom);
                WR = 1'($urandom);
            end else begin
                RD = 1'b0;
                WR = 1'b0;
            end
            if (j < last) step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DATA_W'($urandom);
            ram[i]     = ref_mem[i];
        end

        // Asynchronous reset takes effect without a clock edge.
        #2 ar = 1'b1;
        #1;
        check_val("rst_busy",   Busy, 0);
        check_val("rst_done",   Done, 0);
        check_val("rst_we",     WE, 0);
        check_val("rst_dinreq", DInReq, 0);
        check_val("rst_dvalid", DOutValid, 0);
        check_val("rst_dout",   DOut, 0);
        check_val("rst_data",   Data, 0);
        check_val("rst_wra",    Wr_A, 0);
        check_val("rst_rda",    Rd_A, 0);
        step();
        step();
        ar = 1'b0;

        // Single-word write.
        wd[0] = 16'hBEEF;
        do_write(10'h005, 0, 1'b0, 1'b0);
        do_read(10'h005, 0, 1'b0);

        // Wrapping burst write and read-back, with RD/WR noise while busy.
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        do_write(10'h3FE, 3, 1'b0, 1'b1);
        do_read(10'h3FE, 3, 1'b0);

        // Maximum length, RD=WR=1 at request time.
        for (int i = 0; i < 16; i++) wd[i] = DATA_W'($urandom);
        do_write(10'h3F8, 15, 1'b1, 1'b1);
        do_read(10'h3F8, 15, 1'b1);

        // Reset during beat 2 of a Len=7 write.
        for (int i = 0; i < 16; i++) wd[i] = DATA_W'($urandom);
        WR = 1'b1; A = 10'h100; Len = 4'd7;
        step();
        WR = 1'b0;
        DIn = wd[0];
        step();
        DIn = wd[1];
        step();
        check_val("ab_pre_we", WE, 1);
        ar = 1'b1;
        #1;
        check_val("ab_we",     WE, 0);
        check_val("ab_busy",   Busy, 0);
        check_val("ab_dinreq", DInReq, 0);
        check_val("ab_done",   Done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("ab_hold_we",   WE, 0);
            check_val("ab_hold_done", Done, 0);
            check_val("ab_hold_busy", Busy, 0);
        end
        ar = 1'b0;
        do_write(10'h100, 7, 1'b0, 1'b0);
        do_read(10'h100, 7, 1'b0);

        // Randomised traffic.
        for (int t = 0; t < 30; t++) begin
            logic [ADDR_W-1:0] ra;
            int rl;
            ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            rl = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wd[i] = DATA_W'($urandom);
                do_write(ra, rl, 1'($urandom), 1'($urandom));
            end else begin
                do_read(ra, rl, 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
